buffer_load_array: RTL and testbench



---
 rtl/buffer_pkg.sv | 9 +
 rtl/buffer_load_reg.sv | 36 +++
 rtl/buffer_load_array.sv | 34 +++
 tb/tb_buffer_load_array.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared constants and types for the staging buffer.
package buffer_pkg;

    localparam int unsigned BUF_IWID = 8;
    localparam int unsigned BUF_IDIM = 4;

    typedef logic [BUF_IWID-1:0] buf_word_t;

endpackage

// File: rtl/buffer_load_reg.sv
// One load-enabled holding register with asynchronous active-low clear.
module buffer_load_reg
    import buffer_pkg::*;
#(
    parameter int unsigned IWID = BUF_IWID
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [IWID-1:0] d_i,
    output logic [IWID-1:0] q_o
);

    logic [IWID-1:0] word_d;
    logic [IWID-1:0] word_q;

    // Capture the new word when load is high, otherwise hold.
    always_comb begin
        word_d = word_q;
        if (load) begin
            word_d = d_i;
        end
    end

    // Storage flop; reset clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/buffer_load_array.sv
// Parallel array of IDIM load-enabled word registers that stage data for the
// downstream bitstream generators. Output is purely registered.
module buffer_load_array
    import buffer_pkg::*;
#(
    parameter int unsigned IWID = BUF_IWID,
    parameter int unsigned IDIM = BUF_IDIM
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [IWID-1:0] iData [IDIM-1:0],
    output logic [IWID-1:0] oData [IDIM-1:0]
);

    // Reject degenerate sizes at elaboration.
    if (IWID == 0 || IDIM == 0) begin : g_param_check
        $error("buffer_load_array: IWID and IDIM must both be >= 1");
    end

    // One register per lane; all lanes share clock, reset and load.
    for (genvar i = 0; i < int'(IDIM); i++) begin : g_lane
        buffer_load_reg #(
            .IWID (IWID)
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .d_i   (iData[i]),
            .q_o   (oData[i])
        );
    end

endmodule

// File: tb/tb_buffer_load_array.sv
// Directed bench for buffer_load_array plus two parameter corners driven
// with random traffic against a small reference model.
module tb_buffer_load_array;
    import buffer_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      load;
    buf_word_t i_data [BUF_IDIM-1:0];
    buf_word_t o_data [BUF_IDIM-1:0];
    buf_word_t exp_w  [BUF_IDIM-1:0];

    // IWID=1, IDIM=1 corner
    logic       ld_a;
    logic [0:0] di_a [0:0];
    logic [0:0] do_a [0:0];
    logic [0:0] m_a;

    // IWID=16, IDIM=8 corner
    logic        ld_b;
    logic [15:0] di_b [7:0];
    logic [15:0] do_b [7:0];
    logic [15:0] m_b  [7:0];

    int n_cmp;
    int n_err;

    buffer_load_array dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .iData (i_data),
        .oData (o_data)
    );

    buffer_load_array #(
        .IWID (1),
        .IDIM (1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld_a),
        .iData (di_a),
        .oData (do_a)
    );

    buffer_load_array #(
        .IWID (16),
        .IDIM (8)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld_b),
        .iData (di_b),
        .oData (do_b)
    );

    // Rising edges at 7, 17, 27, ... so reset release at 15 sits between edges.
    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic check_lanes(input string tag);
        for (int i = 0; i < int'(BUF_IDIM); i++) begin
            check($sformatf("%s[%0d]", tag, i), 16'(o_data[i]), 16'(exp_w[i]));
        end
    endtask

    task automatic check_corners_zero(input string tag);
        check($sformatf("%s_a", tag), 16'(do_a[0]), 16'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_b[%0d]", tag, i), do_b[i], 16'h0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        load  = 1'b1;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        di_a[0] = 1'b0;
        for (int i = 0; i < 8; i++) di_b[i] = '0;
        // i_data deliberately left undriven during reset

        // Reset: zero throughout, no clock needed, no X
        exp_w = '{8'd0, 8'd0, 8'd0, 8'd0};
        #3;
        check_lanes("rst_t3");
        @(posedge clk); #1;
        check_lanes("rst_edge");
        check_corners_zero("rst_corner");
        #5;
        check_lanes("rst_t13");

        // Release at t=15 with first load vector; nothing changes before the edge
        #2;
        rst_n  = 1'b1;
        i_data = '{8'd10, 8'd1, 8'd8, 8'd9};
        load   = 1'b1;
        #1;
        check_lanes("pre_edge");
        @(posedge clk); #1;
        exp_w = '{8'd10, 8'd1, 8'd8, 8'd9};
        check_lanes("first_load");

        // Only lane 2 differs
        @(negedge clk);
        i_data = '{8'd10, 8'd2, 8'd8, 8'd9};
        @(posedge clk); #1;
        exp_w = '{8'd10, 8'd2, 8'd8, 8'd9};
        check_lanes("one_lane");

        // Hold for 40 edges while iData changes
        @(negedge clk);
        load   = 1'b0;
        i_data = '{8'd0, 8'd255, 8'd7, 8'd3};
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            check_lanes($sformatf("hold%0d", c));
        end

        // Short reset pulse between edges clears immediately
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_w = '{8'd0, 8'd0, 8'd0, 8'd0};
        check_lanes("mid_rst");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_lanes("post_rst_hold");
        check_corners_zero("post_rst_corner");
        @(negedge clk);
        load   = 1'b1;
        i_data = '{8'd255, 8'd0, 8'd128, 8'd1};
        @(posedge clk); #1;
        exp_w = '{8'd255, 8'd0, 8'd128, 8'd1};
        check_lanes("reload");

        // Parameter corners: random traffic, first cycle loads all-ones
        m_a = 1'b0;
        for (int i = 0; i < 8; i++) m_b[i] = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin
                ld_a    = 1'b1;
                ld_b    = 1'b1;
                di_a[0] = 1'b1;
                for (int i = 0; i < 8; i++) di_b[i] = 16'hFFFF;
            end else begin
                ld_a    = (c == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                ld_b    = (c == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                di_a[0] = 1'($urandom_range(0, 1));
                for (int i = 0; i < 8; i++) di_b[i] = 16'($urandom);
            end
            if (ld_a) m_a = di_a[0];
            if (ld_b) begin
                for (int i = 0; i < 8; i++) m_b[i] = di_b[i];
            end
            @(posedge clk); #1;
            check($sformatf("sw_a_c%0d", c), 16'(do_a[0]), 16'(m_a));
            for (int i = 0; i < 8; i++) begin
                check($sformatf("sw_b_c%0d[%0d]", c, i), do_b[i], m_b[i]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
